mult_booth: RTL and testbench

- Sequential signed 32x32 multiplier for the multicycle MIPS datapath.
- It is the inverse arithmetic partner of the iterative divider and shares its Hi/Lo result convention: Hi holds product[63:32] and Lo holds product[31:0].
- It uses radix-2 Booth recoding, one step per clock, and is started by the control unit with a single-cycle multStart pulse.

---
 rtl/mult_booth.sv | 91 +++++++++
 tb/tb_mult_booth.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mult_booth.sv
// mult_booth: sequential signed 32x32 radix-2 Booth multiplier, 33 steps, Hi/Lo result.
// Define MULT_UNSIGNED_EN to add the multUnsigned port (zero-extended operands for multu).
module mult_booth (
    input  logic        clk,
    input  logic        reset,
    input  logic        multStart,
`ifdef MULT_UNSIGNED_EN
    input  logic        multUnsigned,
`endif
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        multBusy,
    output logic        multDone,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] m_q, m_d, acc_q, acc_d, q_q, q_d, sum;
    logic        qm1_q, qm1_d, done_q, done_d, ext_a, ext_b;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
`ifdef MULT_UNSIGNED_EN
    assign ext_a = multUnsigned ? 1'b0 : A[31];
    assign ext_b = multUnsigned ? 1'b0 : B[31];
`else
    assign ext_a = A[31];
    assign ext_b = B[31];
`endif
    assign sum = ({q_q[0], qm1_q} == 2'b01) ? acc_q + m_q :
                 ({q_q[0], qm1_q} == 2'b10) ? acc_q - m_q : acc_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (multStart) begin
                state_d = RUN;
                cnt_d   = 6'd33;
                m_d     = {ext_a, A};
                acc_d   = '0;
                q_d     = {ext_b, B};
                qm1_d   = 1'b0;
            end
        end else begin
            acc_d = {sum[32], sum[32:1]};
            q_d   = {sum[0], q_q[32:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                state_d = IDLE;
                hi_d    = {acc_d[30:0], q_d[32]};
                lo_d    = q_d[31:0];
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign multBusy = (state_q == RUN);
    assign multDone = done_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;
endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: directed self-checking bench for mult_booth.
module tb_mult_booth;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        multStart = 1'b0;
    logic        multUnsigned = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic        multBusy, multDone;
    logic [31:0] Hi, Lo;
    int total = 0, bad = 0;

    mult_booth dut (
        .clk(clk), .reset(reset), .multStart(multStart),
`ifdef MULT_UNSIGNED_EN
        .multUnsigned(multUnsigned),
`endif
        .A(A), .B(B), .multBusy(multBusy), .multDone(multDone), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic u);
        @(negedge clk);
        A = a; B = b; multUnsigned = u; multStart = 1'b1;
        @(posedge clk); #1;
        multStart = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = multBusy ? 1 : 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (multBusy) busy_cnt++;
        end while (!multDone && cyc < 100);
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({Hi, Lo, multBusy, multDone} !== 66'd0) begin
            bad++;
            $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b want all 0", Hi, Lo, multBusy, multDone);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_latency;
        int cyc, bc;
        start(32'd7, 32'd3, 1'b0);
        total++;
        if (multBusy !== 1'b1) begin bad++; $display("FAIL busy_after_start got %b want 1", multBusy); end
        wait_done(cyc, bc);
        total++;
        if (cyc !== 33) begin bad++; $display("FAIL latency got %0d want 33", cyc); end
        total++;
        if (bc !== 33) begin bad++; $display("FAIL busy_cycles got %0d want 33", bc); end
        total++;
        if ({Hi, Lo} !== 64'h00000000_00000015) begin bad++; $display("FAIL mul_7x3 got %h_%h want 00000000_00000015", Hi, Lo); end
        @(posedge clk); #1;
        total++;
        if (multDone !== 1'b0) begin bad++; $display("FAIL done_pulse_width got %b want 0", multDone); end
    endtask

    task automatic test_signed;
        logic [31:0] ta [6], tb_ [6], th [6], tl [6];
        int cyc, bc;
        ta  = '{32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h00000003};
        tb_ = '{32'h00000003, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE};
        th  = '{32'hFFFFFFFF, 32'h40000000, 32'h00000000, 32'h00000000, 32'h3FFFFFFF, 32'hFFFFFFFF};
        tl  = '{32'hFFFFFFEB, 32'h00000000, 32'h00000001, 32'h00000000, 32'h00000001, 32'hFFFFFFFA};
        for (int i = 0; i < 6; i++) begin
            start(ta[i], tb_[i], 1'b0);
            wait_done(cyc, bc);
            total++;
            if (cyc !== 33 || {Hi, Lo} !== {th[i], tl[i]}) begin
                bad++;
                $display("FAIL signed_%0d a=%h b=%h got %h_%h cyc=%0d want %h_%h cyc=33", i, ta[i], tb_[i], Hi, Lo, cyc, th[i], tl[i]);
            end
        end
    endtask

`ifdef MULT_UNSIGNED_EN
    task automatic test_unsigned;
        int cyc, bc;
        start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done(cyc, bc);
        total++;
        if (cyc !== 33 || {Hi, Lo} !== 64'hFFFFFFFE_00000001) begin
            bad++;
            $display("FAIL multu_ffff got %h_%h cyc=%0d want FFFFFFFE_00000001 cyc=33", Hi, Lo, cyc);
        end
    endtask
`endif

    task automatic test_restart_ignored;
        int cyc, bc, dones;
        start(32'd7, 32'd3, 1'b0);
        wait_done(cyc, bc);
        start(32'd5, 32'd6, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk);
        A = 32'd9; B = 32'd9; multStart = 1'b1;
        @(posedge clk); #1;
        multStart = 1'b0;
        total++;
        if ({Hi, Lo} !== 64'h00000000_00000015 || multBusy !== 1'b1) begin
            bad++;
            $display("FAIL hold_during_run got %h_%h busy=%b want 00000000_00000015 busy=1", Hi, Lo, multBusy);
        end
        wait_done(cyc, bc);
        total++;
        if (cyc !== 23) begin bad++; $display("FAIL restart_latency got %0d want 23", cyc); end
        total++;
        if ({Hi, Lo} !== 64'h00000000_0000001E) begin bad++; $display("FAIL mul_5x6 got %h_%h want 00000000_0000001E", Hi, Lo); end
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (multDone) dones++; end
        total++;
        if (dones !== 0 || multBusy !== 1'b0) begin bad++; $display("FAIL restart_extra_done got dones=%0d busy=%b want 0 0", dones, multBusy); end
    endtask

    task automatic test_async_reset;
        int cyc, bc, dones;
        start(32'd12345, 32'd678, 1'b0);
        repeat (14) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({Hi, Lo, multBusy, multDone} !== 66'd0) begin
            bad++;
            $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b want all 0", Hi, Lo, multBusy, multDone);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (multDone || multBusy) dones++; end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL reset_discard got %0d busy/done cycles want 0", dones); end
        start(32'd2, 32'hFFFFFFFC, 1'b0);
        wait_done(cyc, bc);
        total++;
        if (cyc !== 33 || {Hi, Lo} !== 64'hFFFFFFFF_FFFFFFF8) begin
            bad++;
            $display("FAIL mul_2xm4 got %h_%h cyc=%0d want FFFFFFFF_FFFFFFF8 cyc=33", Hi, Lo, cyc);
        end
    endtask

    task automatic test_operand_change;
        int cyc, bc;
        start(32'd11, 32'd13, 1'b0);
        @(negedge clk); A = 32'hDEADBEEF; B = 32'h12345678;
        wait_done(cyc, bc);
        total++;
        if ({Hi, Lo} !== 64'h00000000_0000008F) begin bad++; $display("FAIL operand_sampled got %h_%h want 00000000_0000008F", Hi, Lo); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_signed;
`ifdef MULT_UNSIGNED_EN
        test_unsigned;
`endif
        test_restart_ignored;
        test_async_reset;
        test_operand_change;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
